bp_me_mem_cmd_arbiter_2to1: RTL

Two-input BedRock stream arbiter that shares a single memory port (e.g. `bp_nonsynth_mem` or the DRAM-side `mem_cmd`/`mem_resp` link) between two cache engines, such as I$ UCE and D$ UCE.
- **Command path:** round-robin arbitration, with the grant locked for a whole multi-beat message until its `last` beat.
- **Response path:** an in-order ID FIFO routes each returning response stream to the requester that issued the matching command. Memory returns responses in command order.

---
 rtl/bp_me_mem_cmd_arbiter_2to1.sv | 87 ++++++++
 1 files changed

// File: rtl/bp_me_mem_cmd_arbiter_2to1.sv
// bp_me_mem_cmd_arbiter_2to1: round-robin 2:1 command merge with an in-order ID FIFO that routes responses back
module bp_me_mem_cmd_arbiter_2to1 #(
  parameter int header_width_p = 64,
  parameter int data_width_p = 64,
  parameter int outstanding_els_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [header_width_p-1:0] cmd_header_i [1:0],
  input  logic [data_width_p-1:0]   cmd_data_i [1:0],
  input  logic [1:0]                cmd_v_i,
  input  logic [1:0]                cmd_last_i,
  output logic [1:0]                cmd_ready_and_o,
  output logic [header_width_p-1:0] mem_cmd_header_o,
  output logic [data_width_p-1:0]   mem_cmd_data_o,
  output logic                      mem_cmd_v_o,
  output logic                      mem_cmd_last_o,
  input  logic                      mem_cmd_ready_and_i,
  input  logic [header_width_p-1:0] mem_resp_header_i,
  input  logic [data_width_p-1:0]   mem_resp_data_i,
  input  logic                      mem_resp_v_i,
  input  logic                      mem_resp_last_i,
  output logic                      mem_resp_ready_and_o,
  output logic [header_width_p-1:0] resp_header_o [1:0],
  output logic [data_width_p-1:0]   resp_data_o [1:0],
  output logic [1:0]                resp_v_o,
  output logic [1:0]                resp_last_o,
  input  logic [1:0]                resp_ready_and_i
);
  localparam int pw_lp = $clog2(outstanding_els_p);
  localparam int cw_lp = $clog2(outstanding_els_p + 1);
  logic lock_q, lock_d, owner_q, owner_d, prio_q, prio_d;
  logic [outstanding_els_p-1:0] fifo_q, fifo_d;
  logic [pw_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cw_lp-1:0] cnt_q, cnt_d;
  logic full, empty, g, en, cmd_hs, push, pop, h;
  assign full = cnt_q == cw_lp'(outstanding_els_p);
  assign empty = cnt_q == '0;
  assign g = lock_q ? owner_q : (&cmd_v_i ? prio_q : cmd_v_i[1]);
  // a full FIFO blocks new messages only; a locked message always continues
  assign en = reset_i & (lock_q | (!full & |cmd_v_i));
  assign mem_cmd_header_o = cmd_header_i[g];
  assign mem_cmd_data_o = cmd_data_i[g];
  assign mem_cmd_last_o = cmd_last_i[g];
  assign mem_cmd_v_o = en & cmd_v_i[g];
  assign cmd_ready_and_o = {2{en & mem_cmd_ready_and_i}} & (g ? 2'b10 : 2'b01);
  assign cmd_hs = mem_cmd_v_o & mem_cmd_ready_and_i;
  assign push = cmd_hs & !lock_q;
  assign h = fifo_q[rptr_q];
  assign mem_resp_ready_and_o = !empty & resp_ready_and_i[h];
  assign resp_v_o = {2{!empty & mem_resp_v_i}} & (h ? 2'b10 : 2'b01);
  assign resp_last_o = {2{mem_resp_last_i}};
  assign pop = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;
  for (genvar i = 0; i < 2; i++) begin : g_resp
    assign resp_header_o[i] = mem_resp_header_i;
    assign resp_data_o[i] = mem_resp_data_i;
  end
  always_comb begin
    lock_d = cmd_hs ? !cmd_last_i[g] : lock_q;
    owner_d = push ? g : owner_q;
    prio_d = (cmd_hs & cmd_last_i[g]) ? !g : prio_q;
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = g;
    wptr_d = push ? ((wptr_q == pw_lp'(outstanding_els_p - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = pop ? ((rptr_q == pw_lp'(outstanding_els_p - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d = cnt_q + cw_lp'(push) - cw_lp'(pop);
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      lock_q <= 1'b0;
      owner_q <= 1'b0;
      prio_q <= 1'b0;
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      lock_q <= lock_d;
      owner_q <= owner_d;
      prio_q <= prio_d;
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  resp_when_empty_a: assert property (@(posedge clk_i) disable iff (!reset_i) !(mem_resp_v_i && empty));
endmodule
